// File: rtl/control_unit.sv
// control_unit: Moore micro-sequencer for a small accumulator CPU.
// Walks FETCH0..FETCH2, DECODE, then up to three execute states chosen by the
// opcode in ir_data, and emits one 16-bit word of micro-operation enables per state.
module control_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ir_data,
   input  logic        acc_sign,
   output logic [15:0] control_signals,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_FETCH0 = 3'd0,
      S_FETCH1 = 3'd1,
      S_FETCH2 = 3'd2,
      S_DECODE = 3'd3,
      S_EX0    = 3'd4,
      S_EX1    = 3'd5,
      S_EX2    = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [7:0] OP_STORE  = 8'h01;
   localparam logic [7:0] OP_LOAD   = 8'h02;
   localparam logic [7:0] OP_ADD    = 8'h03;
   localparam logic [7:0] OP_SUB    = 8'h04;
   localparam logic [7:0] OP_JMPGEZ = 8'h05;
   localparam logic [7:0] OP_JMP    = 8'h06;
   localparam logic [7:0] OP_HALT   = 8'h07;

   // Micro-operation enable bits
   localparam logic [15:0] CS_PC_INC    = 16'h0001;
   localparam logic [15:0] CS_PC_LOAD   = 16'h0002;
   localparam logic [15:0] CS_MAR_PC    = 16'h0004;
   localparam logic [15:0] CS_MAR_MBR   = 16'h0008;
   localparam logic [15:0] CS_MEM_READ  = 16'h0010;
   localparam logic [15:0] CS_MEM_WRITE = 16'h0020;
   localparam logic [15:0] CS_IR_LOAD   = 16'h0040;
   localparam logic [15:0] CS_MBR_ACC   = 16'h0080;
   localparam logic [15:0] CS_ALU_ADD   = 16'h0100;
   localparam logic [15:0] CS_ALU_SUB   = 16'h0200;
   localparam logic [15:0] CS_ACC_LOAD  = 16'h0800;
   localparam logic [15:0] CS_BR_LOAD   = 16'h1000;
   localparam logic [15:0] CS_HALT_IND  = 16'h2000;

   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] w_ctrl;
   logic        w_is_mem_alu;

   // LOAD, ADD and SUB share the three-state read/BR/ACC execute path
   assign w_is_mem_alu = (ir_data == OP_LOAD) || (ir_data == OP_ADD) || (ir_data == OP_SUB);

   // State register; reset forces FETCH0 at once, without waiting for a clock edge
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_FETCH0;
      else        r_state <= w_next_state;
   end

   // Next-state selection from current state and opcode
   // NOTE: default assigned first so no path leaves the signal unassigned (no latch).
   always_comb begin
      w_next_state = S_FETCH0;
      case (r_state)
         S_FETCH0: w_next_state = S_FETCH1;
         S_FETCH1: w_next_state = S_FETCH2;
         S_FETCH2: w_next_state = S_DECODE;
         S_DECODE: begin
            if (ir_data == OP_HALT)                           w_next_state = S_HALT;
            else if (ir_data >= OP_STORE && ir_data <= OP_JMP) w_next_state = S_EX0;
            else                                              w_next_state = S_FETCH0;
         end
         S_EX0: begin
            if (w_is_mem_alu || ir_data == OP_STORE) w_next_state = S_EX1;
            else                                     w_next_state = S_FETCH0;
         end
         S_EX1: begin
            if (w_is_mem_alu) w_next_state = S_EX2;
            else              w_next_state = S_FETCH0;
         end
         S_EX2:   w_next_state = S_FETCH0;
         S_HALT:  w_next_state = S_HALT;
         default: w_next_state = S_FETCH0;
      endcase
   end

   // Output decode: enables depend only on current state, opcode and (in EX0) acc_sign
   always_comb begin
      w_ctrl = 16'h0000;
      case (r_state)
         S_FETCH0: w_ctrl = CS_MAR_PC;
         S_FETCH1: w_ctrl = CS_MEM_READ | CS_PC_INC;
         S_FETCH2: w_ctrl = CS_IR_LOAD | CS_MAR_MBR;
         S_DECODE: w_ctrl = 16'h0000;
         S_EX0: begin
            case (ir_data)
               OP_LOAD, OP_ADD, OP_SUB: w_ctrl = CS_MEM_READ;
               OP_STORE:                w_ctrl = CS_MBR_ACC;
               OP_JMP:                  w_ctrl = CS_PC_LOAD;
               OP_JMPGEZ:               w_ctrl = acc_sign ? 16'h0000 : CS_PC_LOAD;
               default:                 w_ctrl = 16'h0000;
            endcase
         end
         S_EX1: begin
            if (w_is_mem_alu)              w_ctrl = CS_BR_LOAD;
            else if (ir_data == OP_STORE)  w_ctrl = CS_MEM_WRITE;
            else                           w_ctrl = 16'h0000;
         end
         S_EX2: begin
            case (ir_data)
               OP_LOAD: w_ctrl = CS_ACC_LOAD;
               OP_ADD:  w_ctrl = CS_ACC_LOAD | CS_ALU_ADD;
               OP_SUB:  w_ctrl = CS_ACC_LOAD | CS_ALU_SUB;
               default: w_ctrl = 16'h0000;
            endcase
         end
         S_HALT:  w_ctrl = CS_HALT_IND;
         default: w_ctrl = 16'h0000;
      endcase
   end

   assign control_signals = w_ctrl;
   assign halted          = (r_state == S_HALT);

endmodule
